// File: rtl/wirelog_pkg.sv
// Shared constants and helpers for the wire-logic lamp bank.
package wirelog_pkg;

  localparam int unsigned LAMP_COUNT_DEF  = 2;
  localparam int unsigned MAX_TOGGLES_DEF = 4;

  // Per-cell status terms reduced at the bank level.
  typedef struct packed {
    logic change;
    logic ovf_set;
  } cell_stat_t;

  // Width of a counter that must hold values 0..max_toggles.
  function automatic int unsigned cnt_width(input int unsigned max_toggles);
    return (max_toggles < 1) ? 1 : $clog2(max_toggles + 1);
  endfunction

endpackage

// File: rtl/lamp_toggle_cell.sv
// One lamp: live toggle bit, frame snapshot bit, optional per-frame toggle limit.
// Toggle limiting is built only when GATE_LAMP_TOGGLE_LIMIT_EN is defined.
module lamp_toggle_cell
  import wirelog_pkg::*;
#(
  parameter logic        INIT_BIT    = 1'b0,
  parameter int unsigned MAX_TOGGLES = MAX_TOGGLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end_i,
  input  logic       trig_i,
  output logic       live_o,
  output logic       snap_o,
  output cell_stat_t stat_c
);

  logic live_q, live_d;
  logic snap_q, snap_d;
  logic accept_c;
  logic ovf_set_c;

`ifdef GATE_LAMP_TOGGLE_LIMIT_EN
  localparam int unsigned CntW = cnt_width(MAX_TOGGLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_limit_c;

  // Trig at the limit is dropped; the frame_end cycle still counts against the closing frame.
  always_comb begin
    at_limit_c = (cnt_q == CntW'(MAX_TOGGLES));
    accept_c   = trig_i & ~at_limit_c;
    ovf_set_c  = trig_i & at_limit_c;
    cnt_d      = frame_end_i ? '0 : cnt_q + CntW'(accept_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb begin
    accept_c  = trig_i;
    ovf_set_c = 1'b0;
  end
`endif

  always_comb begin
    live_d         = live_q ^ accept_c;
    snap_d         = frame_end_i ? live_d : snap_q;
    stat_c.change  = snap_d ^ snap_q;
    stat_c.ovf_set = ovf_set_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= INIT_BIT;
      snap_q <= INIT_BIT;
    end else begin
      live_q <= live_d;
      snap_q <= snap_d;
    end
  end

  assign live_o = live_q;
  assign snap_o = snap_q;

endmodule

// File: rtl/gate_lamp_bank.sv
// Bank of toggle lamps with a frame-stable snapshot, change pulse and sticky overflow.
// Optional per-frame toggle limit: define GATE_LAMP_TOGGLE_LIMIT_EN.
module gate_lamp_bank
  import wirelog_pkg::*;
#(
  parameter int unsigned           LAMP_COUNT  = LAMP_COUNT_DEF,
  parameter logic [LAMP_COUNT-1:0] INIT_STATE  = '0,
  parameter int unsigned           MAX_TOGGLES = MAX_TOGGLES_DEF
) (
  input  logic                  clk,
  input  logic                  logic_reset_n,
  input  logic                  frame_end,
  input  logic [LAMP_COUNT-1:0] trig,
  output logic [LAMP_COUNT-1:0] lamp,
  output logic [LAMP_COUNT-1:0] lamp_live,
  output logic                  eval,
  output logic                  overflow
);

  cell_stat_t stat_c [LAMP_COUNT];
  logic       change_c;
  logic       ovf_set_c;
  logic       eval_q, eval_d;
  logic       overflow_q, overflow_d;

  for (genvar g = 0; g < LAMP_COUNT; g++) begin : g_cell
    lamp_toggle_cell #(
      .INIT_BIT    (INIT_STATE[g]),
      .MAX_TOGGLES (MAX_TOGGLES)
    ) u_cell (
      .clk         (clk),
      .rst_n       (logic_reset_n),
      .frame_end_i (frame_end),
      .trig_i      (trig[g]),
      .live_o      (lamp_live[g]),
      .snap_o      (lamp[g]),
      .stat_c      (stat_c[g])
    );
  end

  // Reduce per-lamp terms; change is only nonzero on a frame_end cycle.
  always_comb begin
    change_c  = 1'b0;
    ovf_set_c = 1'b0;
    for (int unsigned i = 0; i < LAMP_COUNT; i++) begin
      change_c  = change_c  | stat_c[i].change;
      ovf_set_c = ovf_set_c | stat_c[i].ovf_set;
    end
    eval_d     = change_c;
    overflow_d = overflow_q | ovf_set_c;
  end

  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      eval_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      eval_q     <= eval_d;
      overflow_q <= overflow_d;
    end
  end

  assign eval     = eval_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gate_lamp_bank.sv
// Scoreboard bench for gate_lamp_bank (LAMP_COUNT=2, INIT_STATE=2'b10, MAX_TOGGLES=4).
module tb_gate_lamp_bank;

  logic       clk;
  logic       logic_reset_n;
  logic       frame_end;
  logic [1:0] trig;
  logic [1:0] lamp;
  logic [1:0] lamp_live;
  logic       eval;
  logic       overflow;

  int unsigned checks;
  int unsigned errors;
  int unsigned step_no;

  // Expected {lamp_live, lamp, eval, overflow} after each clock edge.
  logic [5:0] exp_q[$];
  int unsigned name_q[$];

  gate_lamp_bank #(
    .LAMP_COUNT  (2),
    .INIT_STATE  (2'b10),
    .MAX_TOGGLES (4)
  ) dut (
    .clk           (clk),
    .logic_reset_n (logic_reset_n),
    .frame_end     (frame_end),
    .trig          (trig),
    .lamp          (lamp),
    .lamp_live     (lamp_live),
    .eval          (eval),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int unsigned id, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d {live,lamp,eval,ovf}: got %b expected %b", id, act, exp);
    end
  endtask

  // Monitor: every edge with a pending expectation is compared.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), {lamp_live, lamp, eval, overflow}, exp_q.pop_front());
    end
  end

  task automatic step(input logic [1:0] t, input logic fe, input logic [1:0] live,
                      input logic [1:0] lmp, input logic ev, input logic ovf);
    @(negedge clk);
    trig      = t;
    frame_end = fe;
    @(posedge clk);
    step_no++;
    exp_q.push_back({live, lmp, ev, ovf});
    name_q.push_back(step_no);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    step_no       = 0;
    logic_reset_n = 1'b0;
    trig          = 2'b00;
    frame_end     = 1'b0;

    // Reset state, with trig/frame_end active to show they are ignored.
    step(2'b11, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    logic_reset_n = 1'b1;
    trig          = 2'b00;
    frame_end     = 1'b0;

    //    trig   fe    live   lamp   ev    ovf
    step(2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0); // same-cycle trig counted in snapshot
    step(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // eval lasts one cycle
    step(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0); // live after one edge, lamp held
    step(2'b00, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0); // even toggles within a frame
    step(2'b01, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0); // no eval
    step(2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0); // back-to-back frames
    step(2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    step(2'b11, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0); // both lamps with frame_end
    step(2'b00, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b01, 2'b11, 1'b0, 1'b0); // lamp stable mid-frame
    step(2'b11, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0);
    step(2'b00, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b01, 1'b0, 2'b11, 2'b10, 1'b0, 1'b0); // pending toggle, then reset

    // Asynchronous reset mid-frame: live returns to INIT immediately.
    @(negedge clk);
    logic_reset_n = 1'b0;
    trig          = 2'b11;
    frame_end     = 1'b1;
    #1;
    step_no++;
    check(step_no, {lamp_live, lamp, eval, overflow}, 6'b10_10_0_0);
    @(posedge clk);
    step_no++;
    exp_q.push_back(6'b10_10_0_0);
    name_q.push_back(step_no);
    @(negedge clk);
    logic_reset_n = 1'b1;
    trig          = 2'b00;
    frame_end     = 1'b0;
    step(2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0); // discarded toggle: no eval

`ifdef GATE_LAMP_TOGGLE_LIMIT_EN
    // Limit of 4 per frame: toggles 5 and 6 dropped, overflow sticky.
    step(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 1'b1);
    step(2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 1'b1);
    step(2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1);
    step(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1); // counter cleared by frame_end
`else
    // Unlimited toggles, overflow stays 0.
    step(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
`endif

    @(negedge clk);
    trig      = 2'b00;
    frame_end = 1'b0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
